power_activity_monitor: RTL and testbench
=========================================

Name: power_activity_monitor

Overview:
- Hardware successor to the testbench-side power bookkeeping; lives in the power-gating subsystem beside the gating controllers.
- Each cycle, classifies each of NUM_CH gated domains as active, idle (clock-gated) or power-gated.
- Keeps saturating per-state cycle counters and weighted energy accumulators per channel, plus a baseline accumulator.
- Software or a debug master takes an atomic snapshot and reads it out through a valid/ready beat stream while counting continues.

Parameters:
- NUM_CH, 3, number of monitored domains (1..15)
- CNT_W, 32, width of every cycle counter
- ENERGY_W, 40, width of every energy/baseline accumulator
- WT_W, 8, width of power weights
- W_ACTIVE, 100, energy units per active cycle
- W_IDLE, 50, energy units per idle cycle
- W_GATED, 5, energy units per power-gated cycle

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  count only when high
- clear  in  1  zero all counters/accumulators (not shadow)
- ch_idle  in  NUM_CH  per-domain idle flag
- ch_gated  in  NUM_CH  per-domain power-gated flag
- snap_req  in  1  one-cycle pulse: capture snapshot and start readout
- snap_busy  out  1  readout in progress
- rd_valid  out  1  beat valid
- rd_ready  in  1  consumer accepts beat
- rd_idx  out  4  0..NUM_CH-1 channel beat; NUM_CH = totals beat
- rd_last  out  1  high on totals beat
- rd_cnt_active  out  CNT_W  active cycles (totals beat: total counted cycles)
- rd_cnt_idle  out  CNT_W  idle cycles (totals beat: 0)
- rd_cnt_gated  out  CNT_W  gated cycles (totals beat: 0)
- rd_energy  out  ENERGY_W  channel energy (totals beat: sum of channel energies)
- rd_baseline  out  ENERGY_W  totals beat only: total_cycles*NUM_CH*W_ACTIVE; 0 on channel beats

Behaviour:
- Reset: all counters, accumulators and shadow registers are 0; FSM is IDLE; every output is 0. A reset during readout aborts it.
- Classification, per channel and per cycle with enable=1: ch_gated=1 gives GATED (has priority over idle); else ch_idle=1 gives IDLE; else ACTIVE.
- Per counted cycle:
  - the matching state counter increments by 1;
  - the channel energy accumulator adds the state weight;
  - total_cycles increments by 1;
  - baseline adds NUM_CH*W_ACTIVE;
  - the total-energy accumulator adds the sum of that cycle's channel weights.
- Saturation: every counter and accumulator saturates at its all-ones value and never wraps. Saturating one value does not freeze the others.
- enable=0: nothing updates.
- clear=1: every live counter and accumulator is 0 after the edge, and that cycle's sample is discarded. clear has priority over counting.
- Snapshot timing: snap_req accepted in IDLE at edge t copies the live values as they stood before edge t into the shadow registers, i.e. cycles up to t-1. The live registers update normally at t.
- clear and snap_req in the same cycle: the shadow holds the pre-clear values and the live values become 0.
- FSM states: IDLE, then SEND, then back to IDLE.
  - IDLE to SEND on snap_req; rd_idx=0 and rd_valid=1 from cycle t+1; snap_busy=1 throughout SEND.
  - SEND: a beat transfers when rd_valid & rd_ready. rd_idx advances by 1 per transfer; NUM_CH+1 beats in total.
  - After the transfer of the beat with rd_last=1 (idx=NUM_CH), return to IDLE with rd_valid=0.
  - While rd_ready=0, all rd_* outputs hold stable.
- snap_req while busy: ignored, and the shadow is not overwritten.
- Live counting never stalls for readout.
- Width rule: weights are zero-extended to ENERGY_W before adding.

Decomposition:
- Shared package pwr_mon_pkg holds:
  - state encoding PWR_ACTIVE/PWR_IDLE/PWR_GATED;
  - default weight constants;
  - FSM state typedef;
  - a saturating-add function.
- One sub-module, pwr_chan_counter: per-channel classifier, three counters, energy accumulator and shadow capture. It is instantiated NUM_CH times via generate.
- The top-level holds the totals, the baseline accumulator and the readout FSM.

Test Plan:
- Defaults; enable=1; ch0 active, ch1/ch2 gated for 30 cycles; then snap_req. Expect:
  - ch0: active=30, energy=3000;
  - ch1 and ch2: gated=30, energy=150 each;
  - totals beat: cycles=30, energy=3300, baseline=9000, rd_last=1.
- ch_idle and ch_gated both 1 on ch0 for 10 cycles; snap. Expect ch0 gated=10, idle=0, energy=50.
- CNT_W=4, ENERGY_W=10; 20 active cycles on ch0. Expect active=15 (saturated) and energy=1023 (saturated). Other channels still count correctly.
- Hold rd_ready=0 for 5 cycles after rd_valid rises, then 1. Expect:
  - beat idx=0 stable throughout the stall;
  - exactly 4 transfers, then snap_busy=0;
  - a snap_req issued mid-readout is ignored.
- 12 active cycles on all channels, then clear and snap_req in the same cycle. Expect:
  - readout shows active=12 per channel and baseline=3600;
  - a second snapshot 5 cycles later shows active=5.
- Assert reset during beat idx=1. Expect the next cycle to have rd_valid=0, snap_busy=0, and all counters 0.

Source files
------------

// File: rtl/pwr_mon_pkg.sv
// Shared definitions for the power activity monitor.
//   pwr_state_e : per-domain power state classification
//   DEF_W_*     : default energy weights per cycle in each state
//   rd_state_e  : snapshot readout FSM state
//   sat_add     : unsigned add that clamps at the all-ones value of a given width
package pwr_mon_pkg;

  typedef enum logic [1:0] {
    PWR_ACTIVE = 2'd0,
    PWR_IDLE   = 2'd1,
    PWR_GATED  = 2'd2
  } pwr_state_e;

  localparam int unsigned DEF_W_ACTIVE = 100;
  localparam int unsigned DEF_W_IDLE   = 50;
  localparam int unsigned DEF_W_GATED  = 5;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } rd_state_e;

  // Operands must already be zero-extended values that fit in 'width' bits (width <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (65'd1 << width) - 65'd1;
    return (sum > max) ? max[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/pwr_chan_counter.sv
// Per-domain classifier, saturating state counters, energy accumulator and snapshot shadow.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   enable, clear   : count this cycle / zero live values (clear wins)
//   idle, gated     : domain flags; gated has priority over idle
//   capture         : copy pre-edge live values into the shadow registers
//   weight          : this cycle's energy weight (consumed by the top-level totals)
//   shd_*           : shadow copies presented to the readout path
module pwr_chan_counter
  import pwr_mon_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned ENERGY_W = 40,
  parameter int unsigned WT_W     = 8,
  parameter int unsigned W_ACTIVE = DEF_W_ACTIVE,
  parameter int unsigned W_IDLE   = DEF_W_IDLE,
  parameter int unsigned W_GATED  = DEF_W_GATED
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                idle,
  input  logic                gated,
  input  logic                capture,
  output logic [WT_W-1:0]     weight,
  output logic [CNT_W-1:0]    shd_active,
  output logic [CNT_W-1:0]    shd_idle,
  output logic [CNT_W-1:0]    shd_gated,
  output logic [ENERGY_W-1:0] shd_energy
);

  pwr_state_e state;

  logic [CNT_W-1:0]    cnt_active_q, cnt_active_d;
  logic [CNT_W-1:0]    cnt_idle_q, cnt_idle_d;
  logic [CNT_W-1:0]    cnt_gated_q, cnt_gated_d;
  logic [ENERGY_W-1:0] energy_q, energy_d;

  always_comb begin
    if (gated) begin
      state  = PWR_GATED;
      weight = WT_W'(W_GATED);
    end else if (idle) begin
      state  = PWR_IDLE;
      weight = WT_W'(W_IDLE);
    end else begin
      state  = PWR_ACTIVE;
      weight = WT_W'(W_ACTIVE);
    end
  end

  always_comb begin
    cnt_active_d = cnt_active_q;
    cnt_idle_d   = cnt_idle_q;
    cnt_gated_d  = cnt_gated_q;
    energy_d     = energy_q;
    if (clear) begin
      cnt_active_d = '0;
      cnt_idle_d   = '0;
      cnt_gated_d  = '0;
      energy_d     = '0;
    end else if (enable) begin
      case (state)
        PWR_GATED: cnt_gated_d = CNT_W'(sat_add(64'(cnt_gated_q), 64'd1, CNT_W));
        PWR_IDLE:  cnt_idle_d  = CNT_W'(sat_add(64'(cnt_idle_q), 64'd1, CNT_W));
        default:   cnt_active_d = CNT_W'(sat_add(64'(cnt_active_q), 64'd1, CNT_W));
      endcase
      energy_d = ENERGY_W'(sat_add(64'(energy_q), 64'(weight), ENERGY_W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_active_q <= '0;
      cnt_idle_q   <= '0;
      cnt_gated_q  <= '0;
      energy_q     <= '0;
      shd_active   <= '0;
      shd_idle     <= '0;
      shd_gated    <= '0;
      shd_energy   <= '0;
    end else begin
      cnt_active_q <= cnt_active_d;
      cnt_idle_q   <= cnt_idle_d;
      cnt_gated_q  <= cnt_gated_d;
      energy_q     <= energy_d;
      // Shadow takes the values as they stood before this edge.
      if (capture) begin
        shd_active <= cnt_active_q;
        shd_idle   <= cnt_idle_q;
        shd_gated  <= cnt_gated_q;
        shd_energy <= energy_q;
      end
    end
  end

endmodule

// File: rtl/power_activity_monitor.sv
// Power activity monitor: per-domain state/energy counters, cycle/energy/baseline totals,
// and an atomic snapshot read out as NUM_CH channel beats followed by one totals beat.
// Ports:
//   clk, reset              : clock, synchronous active-high reset (aborts readout)
//   enable, clear           : count this cycle / zero live counters (shadow untouched)
//   ch_idle, ch_gated       : per-domain state flags
//   snap_req                : capture snapshot and start readout (ignored while busy)
//   snap_busy               : readout in progress
//   rd_valid/rd_ready       : beat handshake
//   rd_idx, rd_last         : beat index (NUM_CH = totals beat), last-beat flag
//   rd_cnt_*, rd_energy     : channel counters/energy, or totals on the last beat
//   rd_baseline             : baseline on the totals beat, 0 otherwise
module power_activity_monitor
  import pwr_mon_pkg::*;
#(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned ENERGY_W = 40,
  parameter int unsigned WT_W     = 8,
  parameter int unsigned W_ACTIVE = DEF_W_ACTIVE,
  parameter int unsigned W_IDLE   = DEF_W_IDLE,
  parameter int unsigned W_GATED  = DEF_W_GATED
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [NUM_CH-1:0]   ch_idle,
  input  logic [NUM_CH-1:0]   ch_gated,
  input  logic                snap_req,
  output logic                snap_busy,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [3:0]          rd_idx,
  output logic                rd_last,
  output logic [CNT_W-1:0]    rd_cnt_active,
  output logic [CNT_W-1:0]    rd_cnt_idle,
  output logic [CNT_W-1:0]    rd_cnt_gated,
  output logic [ENERGY_W-1:0] rd_energy,
  output logic [ENERGY_W-1:0] rd_baseline
);

  localparam logic [63:0] BaseInc = 64'(NUM_CH) * 64'(W_ACTIVE);
  localparam logic [3:0]  LastIdx = 4'(NUM_CH);

  rd_state_e state_q;
  logic      capture;

  logic [NUM_CH-1:0][WT_W-1:0]     ch_weight;
  logic [NUM_CH-1:0][CNT_W-1:0]    shd_active;
  logic [NUM_CH-1:0][CNT_W-1:0]    shd_idle;
  logic [NUM_CH-1:0][CNT_W-1:0]    shd_gated;
  logic [NUM_CH-1:0][ENERGY_W-1:0] shd_energy;

  logic [CNT_W-1:0]    tot_cycles_q, tot_cycles_d, shd_cycles;
  logic [ENERGY_W-1:0] tot_energy_q, tot_energy_d, shd_tot_energy;
  logic [ENERGY_W-1:0] baseline_q, baseline_d, shd_baseline;
  logic [63:0]         energy_inc;

  assign capture = snap_req && (state_q == StIdle);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    pwr_chan_counter #(
      .CNT_W    (CNT_W),
      .ENERGY_W (ENERGY_W),
      .WT_W     (WT_W),
      .W_ACTIVE (W_ACTIVE),
      .W_IDLE   (W_IDLE),
      .W_GATED  (W_GATED)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .clear      (clear),
      .idle       (ch_idle[i]),
      .gated      (ch_gated[i]),
      .capture    (capture),
      .weight     (ch_weight[i]),
      .shd_active (shd_active[i]),
      .shd_idle   (shd_idle[i]),
      .shd_gated  (shd_gated[i]),
      .shd_energy (shd_energy[i])
    );
  end

  always_comb begin
    energy_inc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      energy_inc = energy_inc + 64'(ch_weight[i]);
    end
  end

  always_comb begin
    tot_cycles_d = tot_cycles_q;
    tot_energy_d = tot_energy_q;
    baseline_d   = baseline_q;
    if (clear) begin
      tot_cycles_d = '0;
      tot_energy_d = '0;
      baseline_d   = '0;
    end else if (enable) begin
      tot_cycles_d = CNT_W'(sat_add(64'(tot_cycles_q), 64'd1, CNT_W));
      tot_energy_d = ENERGY_W'(sat_add(64'(tot_energy_q), energy_inc, ENERGY_W));
      baseline_d   = ENERGY_W'(sat_add(64'(baseline_q), BaseInc, ENERGY_W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tot_cycles_q   <= '0;
      tot_energy_q   <= '0;
      baseline_q     <= '0;
      shd_cycles     <= '0;
      shd_tot_energy <= '0;
      shd_baseline   <= '0;
    end else begin
      tot_cycles_q <= tot_cycles_d;
      tot_energy_q <= tot_energy_d;
      baseline_q   <= baseline_d;
      if (capture) begin
        shd_cycles     <= tot_cycles_q;
        shd_tot_energy <= tot_energy_q;
        shd_baseline   <= baseline_q;
      end
    end
  end

  // Readout FSM; handshake outputs are registered directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      snap_busy <= 1'b0;
      rd_valid  <= 1'b0;
      rd_idx    <= '0;
      rd_last   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (snap_req) begin
            state_q   <= StSend;
            snap_busy <= 1'b1;
            rd_valid  <= 1'b1;
            rd_idx    <= '0;
            rd_last   <= 1'b0;
          end
        end
        StSend: begin
          if (rd_ready) begin
            if (rd_last) begin
              state_q   <= StIdle;
              snap_busy <= 1'b0;
              rd_valid  <= 1'b0;
              rd_idx    <= '0;
              rd_last   <= 1'b0;
            end else begin
              rd_idx  <= rd_idx + 4'd1;
              rd_last <= (rd_idx + 4'd1) == LastIdx;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Beat data is a pure mux of shadow registers, so it holds while rd_ready is low.
  always_comb begin
    rd_cnt_active = '0;
    rd_cnt_idle   = '0;
    rd_cnt_gated  = '0;
    rd_energy     = '0;
    rd_baseline   = '0;
    if (rd_valid) begin
      if (rd_last) begin
        rd_cnt_active = shd_cycles;
        rd_energy     = shd_tot_energy;
        rd_baseline   = shd_baseline;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (rd_idx == 4'(i)) begin
            rd_cnt_active = shd_active[i];
            rd_cnt_idle   = shd_idle[i];
            rd_cnt_gated  = shd_gated[i];
            rd_energy     = shd_energy[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_power_activity_monitor.sv
module tb_power_activity_monitor;

  localparam int NUM_CH = 3;
  localparam longint unsigned WA = 100;
  localparam longint unsigned WI = 50;
  localparam longint unsigned WG = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, enable, clear, snap_req, rd_ready;
  logic [NUM_CH-1:0] ch_idle, ch_gated;

  // Default-width instance
  logic        snap_busy, rd_valid, rd_last;
  logic [3:0]  rd_idx;
  logic [31:0] rd_cnt_active, rd_cnt_idle, rd_cnt_gated;
  logic [39:0] rd_energy, rd_baseline;

  // Narrow instance for saturation behaviour
  logic       s_snap_busy, s_rd_valid, s_rd_last;
  logic [3:0] s_rd_idx;
  logic [3:0] s_rd_cnt_active, s_rd_cnt_idle, s_rd_cnt_gated;
  logic [9:0] s_rd_energy, s_rd_baseline;

  power_activity_monitor dut (
    .clk (clk), .reset (reset), .enable (enable), .clear (clear),
    .ch_idle (ch_idle), .ch_gated (ch_gated), .snap_req (snap_req),
    .snap_busy (snap_busy), .rd_valid (rd_valid), .rd_ready (rd_ready),
    .rd_idx (rd_idx), .rd_last (rd_last), .rd_cnt_active (rd_cnt_active),
    .rd_cnt_idle (rd_cnt_idle), .rd_cnt_gated (rd_cnt_gated),
    .rd_energy (rd_energy), .rd_baseline (rd_baseline)
  );

  power_activity_monitor #(.CNT_W (4), .ENERGY_W (10)) dut_s (
    .clk (clk), .reset (reset), .enable (enable), .clear (clear),
    .ch_idle (ch_idle), .ch_gated (ch_gated), .snap_req (snap_req),
    .snap_busy (s_snap_busy), .rd_valid (s_rd_valid), .rd_ready (rd_ready),
    .rd_idx (s_rd_idx), .rd_last (s_rd_last), .rd_cnt_active (s_rd_cnt_active),
    .rd_cnt_idle (s_rd_cnt_idle), .rd_cnt_gated (s_rd_cnt_gated),
    .rd_energy (s_rd_energy), .rd_baseline (s_rd_baseline)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: exact (unbounded) sums; saturation applied as min() at compare time,
  // which is equivalent because every increment is non-negative.
  longint unsigned m_act[NUM_CH], m_idl[NUM_CH], m_gat[NUM_CH], m_en[NUM_CH];
  longint unsigned m_cyc, m_ten, m_base;
  longint unsigned s_act[NUM_CH], s_idl[NUM_CH], s_gat[NUM_CH], s_en[NUM_CH];
  longint unsigned s_cyc, s_ten, s_base;
  bit m_busy = 0;
  int m_idx = 0;

  function automatic longint unsigned sat(input longint unsigned v, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_zero_live();
    for (int i = 0; i < NUM_CH; i++) begin
      m_act[i] = 0; m_idl[i] = 0; m_gat[i] = 0; m_en[i] = 0;
    end
    m_cyc = 0; m_ten = 0; m_base = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_zero_live();
      for (int i = 0; i < NUM_CH; i++) begin
        s_act[i] = 0; s_idl[i] = 0; s_gat[i] = 0; s_en[i] = 0;
      end
      s_cyc = 0; s_ten = 0; s_base = 0;
      m_busy = 0; m_idx = 0;
      return;
    end
    if (m_busy) begin
      if (rd_ready) begin
        if (m_idx == NUM_CH) m_busy = 0;
        else m_idx++;
      end
    end else if (snap_req) begin
      s_act = m_act; s_idl = m_idl; s_gat = m_gat; s_en = m_en;
      s_cyc = m_cyc; s_ten = m_ten; s_base = m_base;
      m_busy = 1; m_idx = 0;
    end
    if (clear) begin
      model_zero_live();
    end else if (enable) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_gated[i]) begin m_gat[i]++; m_en[i] += WG; m_ten += WG; end
        else if (ch_idle[i]) begin m_idl[i]++; m_en[i] += WI; m_ten += WI; end
        else begin m_act[i]++; m_en[i] += WA; m_ten += WA; end
      end
      m_cyc++;
      m_base += NUM_CH * WA;
    end
  endtask

  task automatic check_outputs();
    longint unsigned ea, ei, eg, ee, eb;
    if (m_busy) begin
      if (m_idx < NUM_CH) begin
        ea = s_act[m_idx]; ei = s_idl[m_idx]; eg = s_gat[m_idx]; ee = s_en[m_idx]; eb = 0;
      end else begin
        ea = s_cyc; ei = 0; eg = 0; ee = s_ten; eb = s_base;
      end
      check_eq("valid", 64'(rd_valid), 1);
      check_eq("busy", 64'(snap_busy), 1);
      check_eq("idx", 64'(rd_idx), 64'(m_idx));
      check_eq("last", 64'(rd_last), 64'(m_idx == NUM_CH));
      check_eq($sformatf("act[%0d]", m_idx), 64'(rd_cnt_active), sat(ea, 32));
      check_eq($sformatf("idle[%0d]", m_idx), 64'(rd_cnt_idle), sat(ei, 32));
      check_eq($sformatf("gated[%0d]", m_idx), 64'(rd_cnt_gated), sat(eg, 32));
      check_eq($sformatf("energy[%0d]", m_idx), 64'(rd_energy), sat(ee, 40));
      check_eq($sformatf("base[%0d]", m_idx), 64'(rd_baseline), sat(eb, 40));
      check_eq("s_valid", 64'(s_rd_valid), 1);
      check_eq("s_idx", 64'(s_rd_idx), 64'(m_idx));
      check_eq($sformatf("s_act[%0d]", m_idx), 64'(s_rd_cnt_active), sat(ea, 4));
      check_eq($sformatf("s_idle[%0d]", m_idx), 64'(s_rd_cnt_idle), sat(ei, 4));
      check_eq($sformatf("s_gated[%0d]", m_idx), 64'(s_rd_cnt_gated), sat(eg, 4));
      check_eq($sformatf("s_energy[%0d]", m_idx), 64'(s_rd_energy), sat(ee, 10));
      check_eq($sformatf("s_base[%0d]", m_idx), 64'(s_rd_baseline), sat(eb, 10));
    end else begin
      check_eq("idle_valid", 64'(rd_valid), 0);
      check_eq("idle_busy", 64'(snap_busy), 0);
      check_eq("s_idle_valid", 64'(s_rd_valid), 0);
      check_eq("s_idle_busy", 64'(s_snap_busy), 0);
    end
  endtask

  task automatic step();
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_ready = 1'b1;
    snap_req = 1'b0;
    while (m_busy && n < 64) begin
      step();
      n++;
    end
    step();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(rd_valid), 0);
    check_eq({tag, "_busy"}, 64'(snap_busy), 0);
    check_eq({tag, "_idx"}, 64'(rd_idx), 0);
    check_eq({tag, "_last"}, 64'(rd_last), 0);
    check_eq({tag, "_act"}, 64'(rd_cnt_active), 0);
    check_eq({tag, "_idle"}, 64'(rd_cnt_idle), 0);
    check_eq({tag, "_gated"}, 64'(rd_cnt_gated), 0);
    check_eq({tag, "_energy"}, 64'(rd_energy), 0);
    check_eq({tag, "_base"}, 64'(rd_baseline), 0);
  endtask

  initial begin
    model_zero_live();
    reset = 1'b1; enable = 1'b0; clear = 1'b0; snap_req = 1'b0; rd_ready = 1'b0;
    ch_idle = '0; ch_gated = '0;
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    check_zero("rst");

    // ch0 active, ch1/ch2 gated for 30 cycles
    enable = 1'b1;
    ch_gated = 3'b110;
    repeat (30) step();
    snap();
    drain();

    // idle and gated both set on ch0: gated wins
    clear = 1'b1; step(); clear = 1'b0;
    ch_idle = 3'b001; ch_gated = 3'b001;
    repeat (10) step();
    snap();
    drain();

    // 20 active cycles saturate the narrow instance
    clear = 1'b1; step(); clear = 1'b0;
    ch_idle = '0; ch_gated = '0;
    repeat (20) step();
    snap();
    drain();

    // stalled readout with an ignored mid-readout snap_req
    rd_ready = 1'b0;
    snap();
    repeat (2) step();
    snap();
    repeat (2) step();
    drain();

    // clear and snap in the same cycle, then a later snapshot
    clear = 1'b1; step(); clear = 1'b0;
    repeat (12) step();
    clear = 1'b1; snap_req = 1'b1;
    step();
    clear = 1'b0; snap_req = 1'b0;
    drain();
    snap();
    drain();

    // reset during beat idx=1
    ch_gated = 3'b010; ch_idle = 3'b100;
    repeat (7) step();
    rd_ready = 1'b1;
    snap();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_zero("rst_mid");
    snap();
    drain();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      ch_idle  = NUM_CH'($urandom);
      ch_gated = NUM_CH'($urandom);
      clear    = ($urandom_range(0, 59) == 0);
      snap_req = ($urandom_range(0, 11) == 0);
      rd_ready = ($urandom_range(0, 2) != 0);
      reset    = ($urandom_range(0, 249) == 0);
      step();
    end
    reset = 1'b0; clear = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
